oldland_lsu: RTL
================

Name: oldland_lsu

Overview:
- Parametrised load/store unit replacing the combinational memory-stage data path with a registered, handshaked bus master.
- Sits between the execute/memory pipeline stage and the data bus.
- Accepts one request at a time. Performs lane steering, byte enables and sign/zero extension.
- Detects misalignment, bus error and bus timeout, and returns a single registered response per request.

Parameters:
- DATA_WIDTH, 32: bus and register data width; legal values 32 or 64.
- ADDR_WIDTH, 32: request/bus address width.
- TIMEOUT_CYCLES, 255: cycles d_access may stay unacknowledged before faulting; 0 disables the timeout.
- RD_WIDTH, 4: destination register index width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_store  in  1  1 = store, 0 = load
- req_width  in  2  0 = byte, 1 = half, 2 = word, 3 = dword
- req_signed  in  1  sign-extend load data
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  store data, right-justified
- req_rd  in  RD_WIDTH  load destination register
- d_addr  out  ADDR_WIDTH  bus address, aligned to DATA_WIDTH/8
- d_bytesel  out  DATA_WIDTH/8  byte enables
- d_wr_en  out  1  bus write
- d_wr_val  out  DATA_WIDTH  lane-shifted store data
- d_access  out  1  bus cycle active
- d_data  in  DATA_WIDTH  bus read data
- d_ack  in  1  bus completion
- d_error  in  1  bus error completion
- resp_valid  out  1  one-cycle response strobe
- resp_data  out  DATA_WIDTH  extended load data; 0 for stores and faults
- resp_rd  out  RD_WIDTH  destination register
- resp_update_rd  out  1  write resp_data to resp_rd
- resp_fault  out  1  request faulted
- resp_cause  out  2  0 = none, 1 = misaligned/illegal width, 2 = bus error, 3 = timeout
- resp_fault_addr  out  ADDR_WIDTH  faulting req_addr

Behaviour:
- Reset (asynchronous, active-low):
  - State enters IDLE.
  - All outputs are 0, except req_ready = 1.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready = 1.
  - When req_valid is high, the request is latched.
  - Misaligned check: addr mod 2^req_width != 0.
  - Illegal width: req_width = 3 with DATA_WIDTH = 32.
  - A misaligned or illegal-width request goes to RESP with cause 1 and no bus cycle.
  - Any other request goes to ACCESS.
- ACCESS:
  - req_ready = 0.
  - d_access = 1 from the cycle after acceptance, held until completion.
  - d_addr, d_bytesel, d_wr_en and d_wr_val are registered and stable throughout.
  - d_bytesel = ((1 << 2^req_width) - 1) << lane, where lane = addr mod (DATA_WIDTH/8).
  - d_wr_val = req_wdata << (8 * lane).
  - Timeout counter: cleared on entry, incremented each ACCESS cycle.
- ACCESS exits (checked in this priority):
  - d_error → RESP, cause 2.
  - d_ack → RESP, capturing (d_data >> 8*lane), masked to 8·2^width bits and sign/zero extended per req_signed.
  - Counter reaches TIMEOUT_CYCLES (when nonzero) → RESP, cause 3.
  - d_access deasserts on the exit cycle's next edge.
  - d_error and d_ack in the same cycle: the error wins.
  - d_ack on the timeout cycle: the ack wins.
- RESP:
  - resp_valid = 1 for exactly one cycle, then IDLE.
  - resp_update_rd = load and no fault.
  - resp_rd = latched req_rd.
  - resp_fault_addr is valid when resp_fault = 1.
- Latency:
  - Accept at cycle N; d_access at N+1.
  - Ack at cycle M gives resp_valid at M+1.
  - A fault-before-bus request gives resp_valid at N+1.
- Throughput: the next request can be accepted in the cycle after resp_valid.
- d_ack or d_error seen outside ACCESS is ignored.
- Reset asserted mid-ACCESS drops d_access immediately; no response is generated.

Test Plan:
- DATA_WIDTH = 32, word load at addr 0x1000, d_data = 0xDEADBEEF, ack after 3 cycles → d_bytesel = 0xF; resp_valid 1 cycle after ack; resp_data = 0xDEADBEEF; resp_update_rd = 1.
- Signed byte load at addr 0x1003, d_data = 0x80123456 → d_bytesel = 0x8; resp_data = 0xFFFFFF80. The same load unsigned → 0x00000080.
- Half store at addr 0x2002, wdata = 0xABCD → d_addr = 0x2000; d_bytesel = 0xC; d_wr_val = 0xABCD0000; d_wr_en = 1; resp_update_rd = 0.
- Word load at addr 0x1001 → no d_access; resp_fault = 1; cause 1; resp_fault_addr = 0x1001 at N+1.
- TIMEOUT_CYCLES = 4 with no ack → d_access high for 4 cycles; resp cause 3. Separately, d_ack and d_error asserted together → cause 2.
- DATA_WIDTH = 64, dword load at addr 0x8 with d_data = 0x0123456789ABCDEF → d_bytesel = 0xFF; resp_data is the full value. Also assert rst_n low mid-ACCESS → d_access = 0 and no resp_valid.

Source files
------------

// File: rtl/oldland_lsu_if.sv
// Request, data-bus and response signals of the oldland load/store unit.
// The master modport is the LSU itself (requester of the data bus); the
// slave modport is the surrounding pipeline stage plus the bus fabric.
interface oldland_lsu_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int RD_WIDTH   = 4
);
    // Request channel from the execute/memory stage
    logic                      req_valid;
    logic                      req_ready;
    logic                      req_store;
    logic [1:0]                req_width;
    logic                      req_signed;
    logic [ADDR_WIDTH-1:0]     req_addr;
    logic [DATA_WIDTH-1:0]     req_wdata;
    logic [RD_WIDTH-1:0]       req_rd;

    // Data bus
    logic [ADDR_WIDTH-1:0]     d_addr;
    logic [DATA_WIDTH/8-1:0]   d_bytesel;
    logic                      d_wr_en;
    logic [DATA_WIDTH-1:0]     d_wr_val;
    logic                      d_access;
    logic [DATA_WIDTH-1:0]     d_data;
    logic                      d_ack;
    logic                      d_error;

    // Response channel back to the pipeline
    logic                      resp_valid;
    logic [DATA_WIDTH-1:0]     resp_data;
    logic [RD_WIDTH-1:0]       resp_rd;
    logic                      resp_update_rd;
    logic                      resp_fault;
    logic [1:0]                resp_cause;
    logic [ADDR_WIDTH-1:0]     resp_fault_addr;

    modport master (
        input  req_valid, req_store, req_width, req_signed, req_addr, req_wdata, req_rd,
        output req_ready,
        output d_addr, d_bytesel, d_wr_en, d_wr_val, d_access,
        input  d_data, d_ack, d_error,
        output resp_valid, resp_data, resp_rd, resp_update_rd, resp_fault, resp_cause,
               resp_fault_addr
    );

    modport slave (
        output req_valid, req_store, req_width, req_signed, req_addr, req_wdata, req_rd,
        input  req_ready,
        input  d_addr, d_bytesel, d_wr_en, d_wr_val, d_access,
        output d_data, d_ack, d_error,
        input  resp_valid, resp_data, resp_rd, resp_update_rd, resp_fault, resp_cause,
               resp_fault_addr
    );
endinterface

// File: rtl/oldland_lsu.sv
// Registered load/store unit: accepts one request at a time, runs a single
// handshaked bus cycle with lane steering and byte enables, extends load
// data, and reports misalignment, bus error or timeout in a one-cycle
// registered response.
module oldland_lsu #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int RD_WIDTH       = 4
) (
    input logic           clk,
    input logic           rst_n,
    oldland_lsu_if.master bus
);
    localparam int BYTES     = DATA_WIDTH / 8;
    localparam int LANE_BITS = $clog2(BYTES);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_ALIGN   = 2'd1;
    localparam logic [1:0] CAUSE_BUSERR  = 2'd2;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

    // Latched request
    logic [1:0]            state_q, state_d;
    logic                  store_q, store_d;
    logic [1:0]            width_q, width_d;
    logic                  signed_q, signed_d;
    logic [LANE_BITS-1:0]  lane_q, lane_d;
    logic [RD_WIDTH-1:0]   rd_q, rd_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           cnt_q, cnt_d;

    // Bus outputs
    logic [ADDR_WIDTH-1:0] d_addr_q, d_addr_d;
    logic [BYTES-1:0]      d_bytesel_q, d_bytesel_d;
    logic                  d_wr_en_q, d_wr_en_d;
    logic [DATA_WIDTH-1:0] d_wr_val_q, d_wr_val_d;
    logic                  d_access_q, d_access_d;

    // Response outputs
    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
    logic [RD_WIDTH-1:0]   resp_rd_q, resp_rd_d;
    logic                  resp_update_rd_q, resp_update_rd_d;
    logic                  resp_fault_q, resp_fault_d;
    logic [1:0]            resp_cause_q, resp_cause_d;
    logic [ADDR_WIDTH-1:0] resp_fault_addr_q, resp_fault_addr_d;

    // Request decode helpers
    logic                  req_misaligned;
    logic                  req_illegal;
    logic [LANE_BITS-1:0]  req_lane;
    logic [7:0]            req_mask8;
    logic [BYTES-1:0]      req_mask;

    // Load extraction helpers
    logic [DATA_WIDTH-1:0] ld_shift;
    logic [DATA_WIDTH-1:0] ld_mask;
    logic [31:0]           ld_nbits;
    logic                  ld_sign;
    logic [DATA_WIDTH-1:0] ld_ext;
    logic                  timeout_hit;

    assign bus.req_ready       = (state_q == S_IDLE);
    assign bus.d_addr          = d_addr_q;
    assign bus.d_bytesel       = d_bytesel_q;
    assign bus.d_wr_en         = d_wr_en_q;
    assign bus.d_wr_val        = d_wr_val_q;
    assign bus.d_access        = d_access_q;
    assign bus.resp_valid      = resp_valid_q;
    assign bus.resp_data       = resp_data_q;
    assign bus.resp_rd         = resp_rd_q;
    assign bus.resp_update_rd  = resp_update_rd_q;
    assign bus.resp_fault      = resp_fault_q;
    assign bus.resp_cause      = resp_cause_q;
    assign bus.resp_fault_addr = resp_fault_addr_q;

    // Decode alignment, lane and byte-enable pattern of the incoming request
    always_comb begin
        req_lane = bus.req_addr[LANE_BITS-1:0];
        case (bus.req_width)
            2'd0:    req_misaligned = 1'b0;
            2'd1:    req_misaligned = bus.req_addr[0];
            2'd2:    req_misaligned = |bus.req_addr[1:0];
            default: req_misaligned = |bus.req_addr[2:0];
        endcase
        req_illegal = (bus.req_width == 2'd3) && (DATA_WIDTH == 32);
        case (bus.req_width)
            2'd0:    req_mask8 = 8'h01;
            2'd1:    req_mask8 = 8'h03;
            2'd2:    req_mask8 = 8'h0F;
            default: req_mask8 = 8'hFF;
        endcase
        req_mask = req_mask8[BYTES-1:0];
    end

    // Right-justify the acked lane, mask to the access width and extend
    always_comb begin
        ld_shift = bus.d_data >> {lane_q, 3'b000};
        ld_nbits = 32'd8 << width_q;
        ld_mask  = '0;
        ld_sign  = 1'b0;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            ld_mask[i] = (i < ld_nbits);
            if (i + 1 == ld_nbits)
                ld_sign = ld_shift[i];
        end
        ld_ext = (ld_shift & ld_mask) | ((signed_q && ld_sign) ? ~ld_mask : '0);
        timeout_hit = (TIMEOUT_CYCLES != 0) && ((cnt_q + 32'd1) == 32'(TIMEOUT_CYCLES));
    end

    // Next-state logic; response fields default to zero so they only carry
    // a value during the single resp_valid cycle
    always_comb begin
        state_d           = state_q;
        store_d           = store_q;
        width_d           = width_q;
        signed_d          = signed_q;
        lane_d            = lane_q;
        rd_d              = rd_q;
        addr_d            = addr_q;
        cnt_d             = cnt_q;
        d_addr_d          = d_addr_q;
        d_bytesel_d       = d_bytesel_q;
        d_wr_en_d         = d_wr_en_q;
        d_wr_val_d        = d_wr_val_q;
        d_access_d        = d_access_q;
        resp_valid_d      = 1'b0;
        resp_data_d       = '0;
        resp_rd_d         = '0;
        resp_update_rd_d  = 1'b0;
        resp_fault_d      = 1'b0;
        resp_cause_d      = CAUSE_NONE;
        resp_fault_addr_d = '0;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    store_d  = bus.req_store;
                    width_d  = bus.req_width;
                    signed_d = bus.req_signed;
                    lane_d   = req_lane;
                    rd_d     = bus.req_rd;
                    addr_d   = bus.req_addr;
                    cnt_d    = '0;
                    if (req_misaligned || req_illegal) begin
                        state_d           = S_RESP;
                        resp_valid_d      = 1'b1;
                        resp_rd_d         = bus.req_rd;
                        resp_fault_d      = 1'b1;
                        resp_cause_d      = CAUSE_ALIGN;
                        resp_fault_addr_d = bus.req_addr;
                    end else begin
                        state_d     = S_ACCESS;
                        d_access_d  = 1'b1;
                        d_addr_d    = bus.req_addr & ~ADDR_WIDTH'(BYTES - 1);
                        d_bytesel_d = req_mask << req_lane;
                        d_wr_en_d   = bus.req_store;
                        d_wr_val_d  = bus.req_wdata << {req_lane, 3'b000};
                    end
                end
            end
            S_ACCESS: begin
                cnt_d     = cnt_q + 32'd1;
                resp_rd_d = rd_q;
                if (bus.d_error) begin
                    resp_valid_d      = 1'b1;
                    resp_fault_d      = 1'b1;
                    resp_cause_d      = CAUSE_BUSERR;
                    resp_fault_addr_d = addr_q;
                end else if (bus.d_ack) begin
                    resp_valid_d     = 1'b1;
                    resp_data_d      = store_q ? '0 : ld_ext;
                    resp_update_rd_d = !store_q;
                end else if (timeout_hit) begin
                    resp_valid_d      = 1'b1;
                    resp_fault_d      = 1'b1;
                    resp_cause_d      = CAUSE_TIMEOUT;
                    resp_fault_addr_d = addr_q;
                end else begin
                    resp_rd_d = '0;
                end
                if (resp_valid_d) begin
                    state_d     = S_RESP;
                    d_access_d  = 1'b0;
                    d_addr_d    = '0;
                    d_bytesel_d = '0;
                    d_wr_en_d   = 1'b0;
                    d_wr_val_d  = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= S_IDLE;
            store_q           <= 1'b0;
            width_q           <= 2'd0;
            signed_q          <= 1'b0;
            lane_q            <= '0;
            rd_q              <= '0;
            addr_q            <= '0;
            cnt_q             <= '0;
            d_addr_q          <= '0;
            d_bytesel_q       <= '0;
            d_wr_en_q         <= 1'b0;
            d_wr_val_q        <= '0;
            d_access_q        <= 1'b0;
            resp_valid_q      <= 1'b0;
            resp_data_q       <= '0;
            resp_rd_q         <= '0;
            resp_update_rd_q  <= 1'b0;
            resp_fault_q      <= 1'b0;
            resp_cause_q      <= CAUSE_NONE;
            resp_fault_addr_q <= '0;
        end else begin
            state_q           <= state_d;
            store_q           <= store_d;
            width_q           <= width_d;
            signed_q          <= signed_d;
            lane_q            <= lane_d;
            rd_q              <= rd_d;
            addr_q            <= addr_d;
            cnt_q             <= cnt_d;
            d_addr_q          <= d_addr_d;
            d_bytesel_q       <= d_bytesel_d;
            d_wr_en_q         <= d_wr_en_d;
            d_wr_val_q        <= d_wr_val_d;
            d_access_q        <= d_access_d;
            resp_valid_q      <= resp_valid_d;
            resp_data_q       <= resp_data_d;
            resp_rd_q         <= resp_rd_d;
            resp_update_rd_q  <= resp_update_rd_d;
            resp_fault_q      <= resp_fault_d;
            resp_cause_q      <= resp_cause_d;
            resp_fault_addr_q <= resp_fault_addr_d;
        end
    end
endmodule
